// File: rtl/discrete_variables_sizes_loader.sv
// discrete_variables_sizes_loader: streams packed beats into the per-variable discrete-choice size table.
//   in_clock/in_reset       : clock, async active-high reset
//   in_start/in_abort       : begin a full table load / cancel a load in progress
//   in_data_valid/in_data   : packed entry beats, lowest index in the LSBs
//   out_data_ready          : beat accepted when high together with in_data_valid
//   out_write_*             : one table write per UNPACK cycle
//   out_busy/out_done       : busy outside IDLE / one-cycle pulse after the last entry
module discrete_variables_sizes_loader #(
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
    parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 2,
    parameter int ENTRIES_PER_BEAT                  = 2
) (
    input  logic                                                      in_clock,
    input  logic                                                      in_reset,
    input  logic                                                      in_start,
    input  logic                                                      in_abort,
    input  logic                                                      in_data_valid,
    input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES*ENTRIES_PER_BEAT-1:0] in_data,
    output logic                                                      out_data_ready,
    output logic                                                      out_write_enable,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]               out_write_index,
    output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0]              out_write_data,
    output logic                                                      out_busy,
    output logic                                                      out_done
);
    localparam int IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int W  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int E  = ENTRIES_PER_BEAT;
    localparam int SW = E > 1 ? $clog2(E) : 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, UNPACK, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   slot;
    logic [W*E-1:0]  shreg;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state <= IDLE;
            idx   <= '0;
            slot  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: if (in_start) begin
                    state <= ACCEPT;
                    idx   <= '0;
                end
                ACCEPT: if (in_abort) state <= IDLE;
                else if (in_data_valid && out_data_ready) begin
                    shreg <= in_data;
                    slot  <= '0;
                    state <= UNPACK;
                end
                UNPACK: begin
                    idx   <= idx + 1'b1;
                    shreg <= shreg >> W;
                    slot  <= slot + 1'b1;
                    if (in_abort) state <= IDLE;
                    else if (slot == SW'(E-1)) state <= (idx == {IW{1'b1}}) ? DONE : ACCEPT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Index/data are forced to 0 outside UNPACK so the write port is quiet when idle.
    assign out_data_ready   = state == ACCEPT;
    assign out_write_enable = state == UNPACK;
    assign out_write_index  = out_write_enable ? idx : '0;
    assign out_write_data   = out_write_enable ? shreg[W-1:0] : '0;
    assign out_busy         = state != IDLE;
    assign out_done         = state == DONE;
endmodule

// File: doc/discrete_variables_sizes_loader.md
Name: discrete_variables_sizes_loader

Overview:
- Runtime writer for the per-variable discrete-choice size table. The table is read by the discrete range randomizer using a variable index.
- Accepts a valid/ready stream of packed beats from the host/config path. Unpacks each beat into one table write per cycle and covers every variable index 0..2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1 in order.
- Each stored entry is the max index of that variable's inside choices, not the count. The loader does not check or modify the value.

Parameters:
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 2: width of the table index. The table depth is 2**this.
- MAX_BIT_WIDTH_OF_DISCRETE_CHOICES, 2: width of one table entry.
- ENTRIES_PER_BEAT, 2: number of entries packed per input beat. It must divide 2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX.

Ports:
- in_clock  input  1  single clock, rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  one-cycle request to begin a full table load.
- in_abort  input  1  cancels a load in progress.
- in_data_valid  input  1  input beat valid.
- in_data  input  MAX_BIT_WIDTH_OF_DISCRETE_CHOICES*ENTRIES_PER_BEAT  packed entries. The entry for the lowest index is in the LSBs.
- out_data_ready  output  1  loader can accept a beat.
- out_write_enable  output  1  table write strobe.
- out_write_index  output  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  table address.
- out_write_data  output  MAX_BIT_WIDTH_OF_DISCRETE_CHOICES  table data.
- out_busy  output  1  high in every state except IDLE.
- out_done  output  1  one-cycle pulse when the last entry has been written.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - The index counter, slot counter and beat shift register clear to 0.
  - All outputs are 0 while reset is high and in the first cycle after release.
- Outputs are Moore-decoded from registered state and datapath only. No input-to-output combinational path exists.
- States:
  - IDLE: ready=0, busy=0. in_start=1 -> ACCEPT, index counter <= 0.
  - ACCEPT: ready=1, busy=1. When in_data_valid && out_data_ready, the beat is latched into the shift register, slot <= 0, -> UNPACK. Without valid, the FSM stays in ACCEPT indefinitely.
  - UNPACK: ready=0, write_enable=1, write_index=index counter, write_data=shift register LSB entry. Each cycle:
    - index++ with wrap to 0 at the max index;
    - the shift register shifts right by one entry;
    - slot++.
    - When slot==ENTRIES_PER_BEAT-1: if the index just written is the max index -> DONE, else -> ACCEPT.
  - DONE: out_done=1, busy=1 for exactly one cycle, -> IDLE.
- Latency:
  - Entry k of a beat (k from 0) appears on the write port in the (k+1)th cycle after the handshake edge.
  - Throughput is one beat per ENTRIES_PER_BEAT+1 cycles.
  - A full load takes depth + depth/ENTRIES_PER_BEAT cycles of ACCEPT/UNPACK plus 1 DONE cycle, assuming valid is always high.
- Boundary conditions:
  - in_start while busy: ignored, no restart.
  - in_start in the DONE cycle: ignored; the FSM still goes to IDLE.
  - in_abort: highest priority in any non-IDLE state; the next state is IDLE.
    - Because the write port is Moore, a write presented in the abort cycle still occurs.
    - No later writes occur and out_done does not pulse.
    - Table entries already written stay written.
  - in_abort in IDLE: no effect.
  - in_abort and in_start together in IDLE: start wins.
  - Valid held high in UNPACK: not accepted, because ready=0. The beat stays pending until the next ACCEPT cycle.
  - Entry values are passed through unmodified; all-ones is legal.
  - Reset asserted mid-load: immediate IDLE. The table may be partially written.

Test Plan:
Defaults are IDX=2, W=2, E=2 unless stated.
- Full load: start; beats 4'b0111 then 4'b0010, valid always high -> writes (0,3), (1,1), (2,2), (3,0) on consecutive UNPACK cycles; ready high only in the two ACCEPT cycles; out_done pulses exactly once, 7 cycles after start is sampled; busy then drops.
- Valid gaps: hold valid low for 5 cycles in ACCEPT before the second beat -> FSM stays in ACCEPT with no writes; the write sequence is unchanged and done is delayed by 5 cycles.
- Abort: in_abort asserted on the second UNPACK cycle of beat 0 -> exactly the writes (0,3), (1,1); no done; busy=0 next cycle. A fresh start then restarts at index 0.
- Start while busy: pulse in_start during UNPACK -> no restart; indices continue 0..3 and exactly one done.
- Async reset mid-load: raise in_reset between clock edges during UNPACK -> write_enable, ready, busy and done drop to 0 immediately without waiting for an edge. After release, with no start, the outputs stay 0.
- ENTRIES_PER_BEAT=1 with in_data 2'b11 on every beat -> ACCEPT and UNPACK alternate; writes go to 0..3, all with data 3; done follows the write to index 3.
